multiplier_arbiter: RTL
=======================

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, which is the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, which is the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester request, level-sensitive.
REQ-006 The block SHALL have port a, input, NREQ*WIDTH bits: operand A; requester i uses a[i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port b, input, NREQ*WIDTH bits: operand B; same packing as a.
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot, registered; pulses for one cycle when the winner's operands are captured.
REQ-009 The block SHALL have port done, output, NREQ bits: one-hot, registered; pulses for one cycle to the owner when result is valid.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: unsigned product of the last completed operation.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE; no other reachable states.
REQ-013 In IDLE with req != 0 at edge E0, the block SHALL select the winner by round-robin, capture a/b of the winner, assert gnt[winner] for cycle E0..E0+1, and go to CALC.
REQ-014 The round-robin search SHALL start at (last_winner+1) mod NREQ; last_winner resets to NREQ-1, so requester 0 wins first.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with gnt=0 and done=0.
REQ-016 CALC SHALL perform an iterative shift-add, one multiplier bit per cycle, for exactly WIDTH cycles (counter 0..WIDTH-1), then go to DONE.
REQ-017 In DONE, the block SHALL register result, assert done[owner] for exactly one cycle (E0+WIDTH+1..E0+WIDTH+2), and return to IDLE.
REQ-018 Total service time SHALL be WIDTH+2 cycles per operation; back-to-back grants occur every WIDTH+2 cycles.
REQ-019 req, a and b SHALL be ignored in CALC and DONE; operand changes after capture SHALL NOT affect the result.
REQ-020 A requester still holding req after its done SHALL be treated as a new request and arbitrated fairly against the others.
REQ-021 result SHALL be the exact unsigned a*b in 2*WIDTH bits with no truncation (31*31=961 at WIDTH=5), and SHALL hold its value until the next DONE.
REQ-022 gnt and done SHALL never be nonzero in the same cycle, and each SHALL have at most one bit set.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously force state=IDLE, gnt=0, done=0, result=0, busy=0, counter=0 and last_winner=NREQ-1.
REQ-024 A reset asserted mid-CALC or in DONE SHALL drop the in-flight operation, and no done SHALL be issued for it after release.
REQ-025 After rst_n deasserts, arbitration SHALL begin on the first rising edge at which req != 0.

Configuration
REQ-026 With macro MULT_ARB_ZERO_SKIP_EN defined, if the captured a or b equals 0, the FSM SHALL go IDLE->DONE directly, with result=0 and done at E0+1..E0+2 (2-cycle service).
REQ-027 With MULT_ARB_ZERO_SKIP_EN undefined, zero operands SHALL take the full WIDTH+2-cycle path with no timing difference.

Verification
REQ-028 The bench SHALL cover reset: rst_n pulsed low at CALC cycle 2 -> all outputs 0 immediately, and no done for 20 cycles after release with req=0.
REQ-029 The bench SHALL cover a single request: req=0001, a0=5, b0=6 -> gnt=0001 for one cycle, done=0001 six cycles after the capture edge, result=30.
REQ-030 The bench SHALL cover maximum operands: a2=31, b2=31 -> done=0100, result=961.
REQ-031 The bench SHALL cover contention: req=1111 held, distinct operands -> grant order 0,1,2,3,0, each done paired with the correct product, with a grant every 7 cycles.
REQ-032 The bench SHALL cover fairness: req=1010 held continuously -> grants alternate 1,3,1,3; requesters 0 and 2 never granted.
REQ-033 The bench SHALL cover zero skip: a1=0, b1=17 -> result=0; done 6 cycles after capture without MULT_ARB_ZERO_SKIP_EN, 1 cycle after capture with it.

Source files
------------

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin arbiter sharing one iterative shift-add multiplier
// Define MULT_ARB_ZERO_SKIP_EN to send zero-operand requests straight to DONE.
module multiplier_arbiter #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a,
    input  logic [NREQ*WIDTH-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] last, win, idx;
    logic found, zero;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0] mplier, sa, sb;
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(last) + 1 + k) % NREQ);
            if (!found && req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign sa = a[int'(win)*WIDTH +: WIDTH];
    assign sb = b[int'(win)*WIDTH +: WIDTH];
`ifdef MULT_ARB_ZERO_SKIP_EN
    assign zero = (sa == '0) || (sb == '0);
`else
    assign zero = 1'b0;
`endif
    assign busy = (state != IDLE);
    always_comb begin
        state_n = (state == IDLE) ? (found ? (zero ? DONE : CALC) : IDLE) :
                  (state == CALC) ? ((cnt == CW'(WIDTH-1)) ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            cnt    <= '0;
            last   <= IW'(NREQ-1);
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (state == IDLE && found) begin
                gnt    <= NREQ'(1) << win;
                last   <= win;
                mcand  <= {{WIDTH{1'b0}}, sa};
                mplier <= sb;
                acc    <= '0;
                cnt    <= '0;
            end
            // one multiplier bit per cycle, LSB first
            if (state == CALC) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (state == DONE) begin
                result <= acc;
                done   <= NREQ'(1) << last;
            end
        end
    end
endmodule
